// File: rtl/arch_defs_pkg.sv
// Shared loader architecture constants and the loader state type.
package arch_defs_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Streams a framed program image into RAM and holds the CPU in reset until a
// frame with a good checksum has been loaded.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for the sync byte, other bytes discarded
// LEN     | next byte is the payload length N
// DATA    | writing payload bytes to RAM, accumulating the checksum
// CSUM    | next byte is compared against the accumulated sum
// DONE    | image good, CPU released; sync byte restarts a load
// ERR     | frame rejected, CPU held; sync byte restarts a load
module program_loader #(
  parameter int DATA_WIDTH = arch_defs_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = arch_defs_pkg::ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = arch_defs_pkg::SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);
  import arch_defs_pkg::*;

  localparam int IDX_W    = ADDR_WIDTH + 1;
  localparam int CAPACITY = 2 ** ADDR_WIDTH;

  loader_state_e         state_q, state_d;
  logic [IDX_W-1:0]      len_q, len_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;
  logic                  accept;

  assign rx_ready = 1'b1;
  assign accept   = rx_valid & rx_ready;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) state_d = ST_LEN;
        end
        ST_LEN: begin
          // Compare in 32 bits so a full-capacity length never truncates.
          if ((rx_data == '0) || (32'(rx_data) > CAPACITY)) begin
            state_d      = ST_ERR;
            load_error_d = 1'b1;
            cpu_hold_d   = 1'b1;
          end else begin
            len_d   = IDX_W'(rx_data);
            idx_d   = '0;
            sum_d   = '0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          ram_we_d   = 1'b1;
          ram_addr_d = idx_q[ADDR_WIDTH-1:0];
          ram_data_d = rx_data;
          sum_d      = sum_q + rx_data;
          idx_d      = idx_q + IDX_W'(1);
          if (idx_q + IDX_W'(1) == len_q) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (rx_data == sum_q) begin
            state_d     = ST_DONE;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            state_d      = ST_ERR;
            load_error_d = 1'b1;
            cpu_hold_d   = 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          if (rx_data == SYNC_BYTE) begin
            state_d      = ST_LEN;
            load_done_d  = 1'b0;
            load_error_d = 1'b0;
            cpu_hold_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames, reset, back-to-back
// and random frames checked against a frame-buffer reference model.
module tb_program_loader;

  logic       clk;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;

  int errors = 0;
  int checks = 0;

  program_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bytes since the last sync are kept in a buffer and the
  // frame rules are applied to the buffer as a whole.
  bit         m_in_frame;
  logic [7:0] m_buf[$];
  bit         m_done, m_err, m_hold;
  bit         m_wr;
  logic [3:0] m_wa;
  logic [7:0] m_wd;
  int         m_wr_cnt;
  int         dut_wr_cnt;

  always @(negedge clk) if (ram_we === 1'b1) dut_wr_cnt++;

  task automatic model_reset();
    m_in_frame = 0; m_buf.delete();
    m_done = 0; m_err = 0; m_hold = 1; m_wr = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int n, s;
    m_wr = 0;
    if (!m_in_frame) begin
      if (b == 8'hA5) begin
        m_in_frame = 1; m_buf.delete();
        m_done = 0; m_err = 0; m_hold = 1;
      end
    end else begin
      m_buf.push_back(b);
      n = int'(m_buf[0]);
      if (m_buf.size() == 1) begin
        if (n == 0 || n > 16) begin m_in_frame = 0; m_err = 1; m_hold = 1; end
      end else if (m_buf.size() <= n + 1) begin
        m_wr = 1; m_wa = 4'(m_buf.size() - 2); m_wd = b; m_wr_cnt++;
      end else begin
        s = 0;
        for (int i = 1; i <= n; i++) s += int'(m_buf[i]);
        if (b == 8'(s)) begin m_done = 1; m_hold = 0; end
        else begin m_err = 1; m_hold = 1; end
        m_in_frame = 0;
      end
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    model_byte(b);
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic gap();
    rx_valid = 1'b0; rx_data = 8'($urandom);
    @(posedge clk); #1;
    m_wr = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 4'h0 || ram_data !== 8'h00 || cpu_hold !== 1'b1 ||
        load_done !== 1'b0 || load_error !== 1'b0 || rx_ready !== 1'b1)
      begin errors++; $display("FAIL reset_state: we=%b addr=%h data=%h hold=%b done=%b err=%b rdy=%b, want 0 0 00 1 0 0 1",
                               ram_we, ram_addr, ram_data, cpu_hold, load_done, load_error, rx_ready); end
    @(negedge clk); reset = 1'b1;
    gap();
    checks++;
    if (cpu_hold !== 1'b1 || ram_we !== 1'b0)
      begin errors++; $display("FAIL reset_release: hold=%b we=%b, want 1 0", cpu_hold, ram_we); end
  endtask

  task automatic test_directed();
    logic [7:0] s[$];
    s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66,
          8'hA5, 8'h02, 8'h0F, 8'hF5, 8'h05,
          8'h00, 8'hFF, 8'hA5, 8'h00,
          8'hA5, 8'h01, 8'h7E, 8'h7E,
          8'hA5, 8'h11,
          8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) s.push_back(8'h01);
    s.push_back(8'h10);
    s.push_back(8'hA5); s.push_back(8'h02); s.push_back(8'hA5);
    s.push_back(8'hA5); s.push_back(8'h4A);
    foreach (s[i]) begin
      push(s[i]);
      checks++;
      if (load_done !== m_done || load_error !== m_err || cpu_hold !== m_hold)
        begin errors++; $display("FAIL dir_flags[%0d]: done/err/hold=%b%b%b, want %b%b%b", i,
                                 load_done, load_error, cpu_hold, m_done, m_err, m_hold); end
      checks++;
      if (ram_we !== m_wr)
        begin errors++; $display("FAIL dir_we[%0d]: got %b, want %b", i, ram_we, m_wr); end
      if (m_wr) begin
        checks++;
        if (ram_addr !== m_wa || ram_data !== m_wd)
          begin errors++; $display("FAIL dir_write[%0d]: got (%h,%h), want (%h,%h)", i, ram_addr, ram_data, m_wa, m_wd); end
      end
    end
    gap();
    checks++;
    if (ram_we !== 1'b0 || load_done !== 1'b1)
      begin errors++; $display("FAIL dir_end: we=%b done=%b, want 0 1", ram_we, load_done); end
    checks++;
    if (dut_wr_cnt !== m_wr_cnt)
      begin errors++; $display("FAIL dir_write_count: got %0d, want %0d", dut_wr_cnt, m_wr_cnt); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] s[$];
    s = '{8'hA5, 8'h04, 8'hAA, 8'hBB};
    foreach (s[i]) push(s[i]);
    @(negedge clk); #1 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 4'h0 || ram_data !== 8'h00 || cpu_hold !== 1'b1 ||
        load_done !== 1'b0 || load_error !== 1'b0)
      begin errors++; $display("FAIL rst_async: we=%b addr=%h data=%h hold=%b done=%b err=%b, want 0 0 00 1 0 0",
                               ram_we, ram_addr, ram_data, cpu_hold, load_done, load_error); end
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = (i == 0) ? 8'hA5 : 8'hCC;
      @(posedge clk); #1;
    end
    @(negedge clk); reset = 1'b1; rx_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      gap();
      checks++;
      if (ram_we !== 1'b0 || cpu_hold !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0)
        begin errors++; $display("FAIL rst_after[%0d]: we=%b hold=%b done=%b err=%b, want 0 1 0 0",
                                 i, ram_we, cpu_hold, load_done, load_error); end
    end
    // From IDLE a length-like byte must be ignored, then a clean frame loads.
    s = '{8'h04, 8'hA5, 8'h01, 8'h33, 8'h33};
    foreach (s[i]) begin
      push(s[i]);
      checks++;
      if (load_done !== m_done || load_error !== m_err || cpu_hold !== m_hold || ram_we !== m_wr)
        begin errors++; $display("FAIL rst_frame[%0d]: done/err/hold/we=%b%b%b%b, want %b%b%b%b", i,
                                 load_done, load_error, cpu_hold, ram_we, m_done, m_err, m_hold, m_wr); end
    end
    checks++;
    if (dut_wr_cnt !== m_wr_cnt)
      begin errors++; $display("FAIL rst_write_count: got %0d, want %0d", dut_wr_cnt, m_wr_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int kind, n, s;
    for (int f = 0; f < 200; f++) begin
      q.delete();
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        q.push_back(8'($urandom_range(0, 255)));
      end else begin
        q.push_back(8'hA5);
        if (kind == 1) begin
          n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
          q.push_back(8'(n));
        end else begin
          n = $urandom_range(1, 16);
          q.push_back(8'(n));
          s = 0;
          for (int i = 0; i < n; i++) begin
            q.push_back(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255)));
            s += int'(q[q.size()-1]);
          end
          q.push_back((kind == 2) ? 8'(s + $urandom_range(1, 255)) : 8'(s));
        end
      end
      foreach (q[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          gap();
          checks++;
          if (ram_we !== 1'b0 || load_done !== m_done || load_error !== m_err || cpu_hold !== m_hold)
            begin errors++; $display("FAIL rnd_gap[%0d]: we=%b done/err/hold=%b%b%b, want 0 %b%b%b", f,
                                     ram_we, load_done, load_error, cpu_hold, m_done, m_err, m_hold); end
        end
        push(q[i]);
        checks++;
        if (load_done !== m_done || load_error !== m_err || cpu_hold !== m_hold)
          begin errors++; $display("FAIL rnd_flags[%0d.%0d]: done/err/hold=%b%b%b, want %b%b%b", f, i,
                                   load_done, load_error, cpu_hold, m_done, m_err, m_hold); end
        checks++;
        if (ram_we !== m_wr)
          begin errors++; $display("FAIL rnd_we[%0d.%0d]: got %b, want %b", f, i, ram_we, m_wr); end
        if (m_wr) begin
          checks++;
          if (ram_addr !== m_wa || ram_data !== m_wd)
            begin errors++; $display("FAIL rnd_write[%0d.%0d]: got (%h,%h), want (%h,%h)", f, i,
                                     ram_addr, ram_data, m_wa, m_wd); end
        end
      end
    end
    gap();
    checks++;
    if (dut_wr_cnt !== m_wr_cnt)
      begin errors++; $display("FAIL rnd_write_count: got %0d, want %0d", dut_wr_cnt, m_wr_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[$];
    s = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4A,
          8'hA5, 8'h01, 8'h7E, 8'h7E,
          8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
          8'hA5, 8'h01, 8'h10, 8'h11,
          8'hA5, 8'h03, 8'h80, 8'h80, 8'h01, 8'h01};
    foreach (s[i]) begin
      push(s[i]);
      checks++;
      if (load_done !== m_done || load_error !== m_err || cpu_hold !== m_hold || ram_we !== m_wr)
        begin errors++; $display("FAIL b2b_flags[%0d]: done/err/hold/we=%b%b%b%b, want %b%b%b%b", i,
                                 load_done, load_error, cpu_hold, ram_we, m_done, m_err, m_hold, m_wr); end
      if (m_wr) begin
        checks++;
        if (ram_addr !== m_wa || ram_data !== m_wd)
          begin errors++; $display("FAIL b2b_write[%0d]: got (%h,%h), want (%h,%h)", i, ram_addr, ram_data, m_wa, m_wd); end
      end
    end
    gap();
    checks++;
    if (dut_wr_cnt !== m_wr_cnt)
      begin errors++; $display("FAIL b2b_write_count: got %0d, want %0d", dut_wr_cnt, m_wr_cnt); end
  endtask

  initial begin
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    m_wr_cnt = 0; dut_wr_cnt = 0;
    model_reset();
    #12;
    test_reset();
    test_directed();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
